// File: rtl/uart_transmitter_if.sv
// CPU-side register bus for the UART transmitter: store strobe, word select,
// write data and the registered status read-back.
interface uart_transmitter_if;
  logic [1:0]  data_addr;
  logic [31:0] data_in;
  logic        write_enable;
  logic [31:0] data_out;

  modport master (
    output data_addr,
    output data_in,
    output write_enable,
    input  data_out
  );

  modport slave (
    input  data_addr,
    input  data_in,
    input  write_enable,
    output data_out
  );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter fed by a small byte FIFO, with a memory-mapped
// DATA/STATUS word and a CONTROL word for clearing the sticky overflow flag.
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  uart_transmitter_if.slave  bus,
  output logic               uart_tx
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [OCC_W-1:0]   count;
  logic               overflow;
  logic [7:0]         shift;
  logic [CNT_W-1:0]   baud_cnt;
  logic [2:0]         bit_idx;

  logic fifo_empty;
  logic fifo_full;
  logic bit_done;
  logic wr_data;
  logic wr_ctrl;
  logic push;
  logic pop;
  logic unused_data;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == OCC_W'(FIFO_DEPTH));
  assign bit_done    = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign wr_data     = bus.write_enable && (bus.data_addr == 2'd0);
  assign wr_ctrl     = bus.write_enable && (bus.data_addr == 2'd1);
  // Full is judged before the edge, so a pop on the same edge never frees room.
  assign push        = wr_data && !fifo_full;
  assign pop         = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));
  assign unused_data = ^bus.data_in[31:8];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + OCC_W'(push) - OCC_W'(pop);
      if (wr_data && fifo_full)
        overflow <= 1'b1;
      else if (wr_ctrl && bus.data_in[0])
        overflow <= 1'b0;
    end
  end

  // Frame sequencer; uart_tx is registered so the line never glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx  <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            state   <= START;
            shift   <= mem[rd_ptr];
            uart_tx <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              uart_tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (pop) begin
              state   <= START;
              shift   <= mem[rd_ptr];
              uart_tx <= 1'b0;
            end else begin
              state   <= IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

  // Status word sampled every cycle from the post-edge state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_out <= 32'h0000_0002;
    end else begin
      bus.data_out <= {16'h0000, 8'(count), 4'h0, overflow, fifo_full,
                       fifo_empty, (state != IDLE)};
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at CLKS_PER_BIT=4, FIFO_DEPTH=8:
// exact line timing, status word, FIFO overflow and mid-frame reset.
module tb_uart_transmitter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_tx;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] rx_q [$];

  uart_transmitter_if bus ();

  uart_transmitter #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  // Line receiver: samples mid-bit, records each byte seen on uart_tx
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      repeat (2) @(negedge clk);
      if (uart_tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (4) @(negedge clk);
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; the store lands on the next rising edge
  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    bus.data_addr    = a;
    bus.data_in      = {24'hDEADBE, d};
    bus.write_enable = 1'b1;
    @(negedge clk);
    bus.write_enable = 1'b0;
    bus.data_in      = 32'h0;
    bus.data_addr    = 2'd0;
  endtask

  task automatic check_frame(input logic [7:0] b, input string name);
    logic exp;
    for (int k = 0; k < 10; k++) begin
      exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (uart_tx !== exp) begin
          errors++;
          $display("FAIL %s bit %0d cycle %0d: uart_tx=%b expected %b", name, k, c, uart_tx, exp);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n = 0;
    while (!(bus.data_out[0] === 1'b0 && bus.data_out[1] === 1'b1) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max_cycles) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles, data_out=%h expected idle/empty", name, n, bus.data_out);
    end
  endtask

  task automatic test_reset;
    bus.data_addr    = 2'd0;
    bus.data_in      = 32'h0;
    bus.write_enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: uart_tx=%b expected 1", uart_tx);
    end
    checks++;
    if (bus.data_out !== 32'h0000_0002) begin
      errors++;
      $display("FAIL reset_status: data_out=%h expected 00000002", bus.data_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_single;
    rx_q.delete();
    do_write(2'd0, 8'h55);
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: uart_tx=%b expected 1 before pop edge", uart_tx);
    end
    checks++;
    if (bus.data_out !== 32'h0000_0002) begin
      errors++;
      $display("FAIL single_no_bypass: data_out=%h expected 00000002", bus.data_out);
    end
    @(negedge clk);
    check_frame(8'h55, "single_55");
    @(negedge clk);
    checks++;
    if (bus.data_out !== 32'h0000_0002) begin
      errors++;
      $display("FAIL single_done_status: data_out=%h expected 00000002", bus.data_out);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      errors++;
      $display("FAIL single_rx: got %0d bytes (first %h) expected 1 byte 55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back;
    rx_q.delete();
    do_write(2'd0, 8'hA5);
    do_write(2'd0, 8'h3C);
    checks++;
    if (bus.data_out !== 32'h0000_0100) begin
      errors++;
      $display("FAIL b2b_status: data_out=%h expected 00000100", bus.data_out);
    end
    check_frame(8'hA5, "b2b_A5");
    check_frame(8'h3C, "b2b_3C");
    @(negedge clk);
    checks++;
    if (bus.data_out !== 32'h0000_0002) begin
      errors++;
      $display("FAIL b2b_done_status: data_out=%h expected 00000002", bus.data_out);
    end
  endtask

  task automatic test_status;
    logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    rx_q.delete();
    for (int i = 0; i < 4; i++) do_write(2'd0, exp_b[i]);
    checks++;
    if (bus.data_out !== 32'h0000_0201) begin
      errors++;
      $display("FAIL status_occ2: data_out=%h expected 00000201", bus.data_out);
    end
    @(negedge clk);
    checks++;
    if (bus.data_out !== 32'h0000_0301) begin
      errors++;
      $display("FAIL status_occ3: data_out=%h expected 00000301", bus.data_out);
    end
    wait_idle(250, "status_idle");
    checks++;
    if (rx_q.size() != 4) begin
      errors++;
      $display("FAIL status_rx_count: got %0d bytes expected 4", rx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rx_q[i] !== exp_b[i]) begin
          errors++;
          $display("FAIL status_rx_byte%0d: got %h expected %h", i, rx_q[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_ignored;
    logic saw_low = 1'b0;
    do_write(2'd2, 8'h77);
    do_write(2'd3, 8'h88);
    do_write(2'd1, 8'h01);
    for (int i = 0; i < 12; i++) begin
      if (uart_tx !== 1'b1) saw_low = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_low) begin
      errors++;
      $display("FAIL ignored_line: uart_tx went low, expected idle line");
    end
    checks++;
    if (bus.data_out !== 32'h0000_0002) begin
      errors++;
      $display("FAIL ignored_status: data_out=%h expected 00000002", bus.data_out);
    end
  endtask

  task automatic test_overflow;
    rx_q.delete();
    for (int i = 0; i < 10; i++) do_write(2'd0, 8'(i));
    checks++;
    if (bus.data_out !== 32'h0000_0805) begin
      errors++;
      $display("FAIL ovf_full: data_out=%h expected 00000805", bus.data_out);
    end
    @(negedge clk);
    checks++;
    if (bus.data_out !== 32'h0000_080D) begin
      errors++;
      $display("FAIL ovf_set: data_out=%h expected 0000080D", bus.data_out);
    end
    do_write(2'd1, 8'h00);
    @(negedge clk);
    checks++;
    if (bus.data_out !== 32'h0000_080D) begin
      errors++;
      $display("FAIL ovf_ctrl_bit0_clear: data_out=%h expected 0000080D", bus.data_out);
    end
    do_write(2'd1, 8'h01);
    @(negedge clk);
    checks++;
    if (bus.data_out !== 32'h0000_0805) begin
      errors++;
      $display("FAIL ovf_clear: data_out=%h expected 00000805", bus.data_out);
    end
    wait_idle(500, "ovf_idle");
    checks++;
    if (rx_q.size() != 9) begin
      errors++;
      $display("FAIL ovf_rx_count: got %0d bytes expected 9", rx_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (rx_q[i] !== 8'(i)) begin
          errors++;
          $display("FAIL ovf_rx_byte%0d: got %h expected %h", i, rx_q[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic saw_low = 1'b0;
    do_write(2'd0, 8'hFF);
    do_write(2'd0, 8'h01);
    do_write(2'd0, 8'h02);
    // 1.5 cycles into the start bit; move into data bit 3 (cycles 16..19)
    repeat (15) @(negedge clk);
    checks++;
    if (bus.data_out !== 32'h0000_0201) begin
      errors++;
      $display("FAIL midrst_pre_status: data_out=%h expected 00000201", bus.data_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async_tx: uart_tx=%b expected 1", uart_tx);
    end
    checks++;
    if (bus.data_out !== 32'h0000_0002) begin
      errors++;
      $display("FAIL midrst_async_status: data_out=%h expected 00000002", bus.data_out);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (uart_tx !== 1'b1) saw_low = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_low) begin
      errors++;
      $display("FAIL midrst_no_resume: uart_tx went low after reset released");
    end
    checks++;
    if (bus.data_out !== 32'h0000_0002) begin
      errors++;
      $display("FAIL midrst_post_status: data_out=%h expected 00000002", bus.data_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_status();
    test_ignored();
    test_overflow();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8: transmit FIFO depth in bytes, a power of two.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-high.
REQ-005 Port data_addr  input  2: local word-select address; 0 = DATA/STATUS, 1 = CONTROL.
REQ-006 Port data_in  input  32: write data from the CPU; only bits [7:0] are used.
REQ-007 Port write_enable  input  1: device-qualified store strobe, one cycle per store.
REQ-008 Port data_out  output  32: registered read data (status word).
REQ-009 Port uart_tx  output  1: serial line, idle high.

Function
REQ-010 The serial frame SHALL be 8N1: start bit 0, data bits [0] through [7] LSB first, one stop bit 1.
REQ-011 Every bit SHALL be held on uart_tx for exactly CLKS_PER_BIT cycles.
REQ-012 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP.
REQ-013 FSM transitions:
- IDLE->START when the FIFO is non-empty; the head byte is popped into the shift register on the same edge.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after 8 bits.
- STOP->START (back-to-back, zero idle gap) when the FIFO is non-empty at the end of the stop bit; otherwise STOP->IDLE.
REQ-014 A write with data_addr=0 SHALL push data_in[7:0] into the FIFO when the FIFO is not full before the edge.
REQ-015 A write with data_addr=0 to a full FIFO SHALL drop the byte, even if a pop occurs on the same edge, and SHALL set the sticky overflow flag.
REQ-016 A simultaneous push and pop on a non-full FIFO SHALL leave the occupancy unchanged and preserve byte order.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL range from 0 to FIFO_DEPTH inclusive.
REQ-018 A write with data_addr=1 SHALL clear overflow when data_in[0]=1 and SHALL have no other effect.
REQ-019 Writes with data_addr of 2 or 3 SHALL be ignored.
REQ-020 Write-to-line latency: for a byte written at edge N into an empty FIFO with the FSM in IDLE, uart_tx SHALL go low after edge N+1.
REQ-021 data_out SHALL be registered every cycle, giving one-cycle read latency, independent of write_enable and data_addr. Bit fields:
- [0] busy (FSM not IDLE)
- [1] empty
- [2] full
- [3] overflow
- [15:8] occupancy
- all other bits 0.
REQ-022 Status fields SHALL reflect the state after the previous edge; a push and the status read of the same cycle do not bypass.
REQ-023 The baud counter and bit index SHALL be internal; no partial frame SHALL be emitted except via reset.

Reset
REQ-024 While rst=1, the block SHALL hold: FSM IDLE, FIFO empty (pointers 0), overflow 0, uart_tx 1, data_out 32'h00000002.
REQ-025 Reset asserted mid-frame SHALL drive uart_tx to 1 immediately (asynchronously), discard the frame and the FIFO contents, and not resume the frame after deassertion.
REQ-026 After rst deasserts, the first write SHALL be accepted on the first clock edge.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-027 Single byte: write 0x55 to addr 0 at edge N -> uart_tx=0 for 4 cycles from edge N+1, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; data_out bit0 returns to 0 afterwards.
REQ-028 Back-to-back: write 0xA5 then 0x3C on consecutive cycles -> two 40-cycle frames with no gap between the stop bit and the next start bit; status goes empty=1, busy=0 after 80 line cycles.
REQ-029 Overflow: 10 writes on consecutive cycles (0x00..0x09) while IDLE -> 0x00 is popped at the second edge, so bytes 0x00..0x08 are sent and 0x09 is dropped; status after the 10th write reads full=1, overflow=1, occupancy=8; write 0x1 to addr 1 -> overflow=0.
REQ-030 Status read: after 3 pushes during a transmission -> data_out=0x00000301 one cycle later (busy=1, occupancy 3).
REQ-031 Reset mid-frame: assert rst during data bit 3 of byte 0xFF with 2 bytes queued -> uart_tx=1 immediately, data_out=0x00000002, no further frames after deassertion.
